// File: rtl/fx3_burst_writer_pkg.sv
// Shared constants for the FX3 slave-FIFO burst writer.
// State encoding and default packet framing parameters.
package fx3_burst_writer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_SHORT = 2'd3;

  localparam int DEF_PACKET_WORDS = 8192;
  localparam int DEF_WM_STOP      = 4;
  localparam int DEF_START_LEVEL  = 8192;

endpackage

// File: rtl/fx3_burst_writer.sv
// Streams FIFO words onto the FX3 GPIF-II bus in fixed-size packets,
// committing a short packet when capture stops mid-packet.
module fx3_burst_writer
  import fx3_burst_writer_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int LEVEL_W      = 14,
  parameter int PACKET_WORDS = DEF_PACKET_WORDS,
  parameter int WM_STOP      = DEF_WM_STOP,
  parameter int START_LEVEL  = DEF_START_LEVEL
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic [DATA_W-1:0] fifoData,
  input  logic              fifoEmpty,
  input  logic [LEVEL_W-1:0] fifoLevel,
  input  logic              fifoFull,
  input  logic              fx3_nReady,
  input  logic              fx3_th0Ready,
  input  logic              fx3_th0Watermark,
  output logic              fifoAck,
  output logic [DATA_W-1:0] fx3_data,
  output logic              fx3_nWrite,
  output logic              fx3_nShort,
  output logic              fx3_nError,
  output logic [15:0]       packetCount
);

  localparam int WC_W = $clog2(PACKET_WORDS + 1);
  localparam logic [WC_W-1:0] WC_LAST =
    WC_W'(PACKET_WORDS - 1);
  localparam logic [WC_W-1:0] WC_WM =
    WC_W'(PACKET_WORDS - WM_STOP);
  localparam logic [LEVEL_W-1:0] LVL_START =
    LEVEL_W'(START_LEVEL);

  logic [1:0]        r_state;
  logic [WC_W-1:0]   r_wordCount;
  logic              r_wmPrev;
  logic [DATA_W-1:0] r_data;
  logic              r_nWrite;
  logic              r_nShort;
  logic              r_nError;
  logic [15:0]       r_packetCount;

  logic w_pop;
  logic w_last;
  logic w_wmFall;
  logic w_wmErr;

  assign w_pop = nReset && (r_state == ST_BURST)
              && !fifoEmpty && !fx3_nReady;
  assign w_last   = (r_wordCount == WC_LAST);
  assign w_wmFall = r_wmPrev && !fx3_th0Watermark;
  // Late watermark is fine; early means FX3 buffers disagree with us
  assign w_wmErr  = w_wmFall && (r_state == ST_BURST)
                 && (r_wordCount < WC_WM);

  assign fifoAck     = w_pop;
  assign fx3_data    = r_data;
  assign fx3_nWrite  = r_nWrite;
  assign fx3_nShort  = r_nShort;
  assign fx3_nError  = r_nError;
  assign packetCount = r_packetCount;

  always_ff @(posedge clock) begin
    if (!nReset) begin
      r_state       <= ST_IDLE;
      r_wordCount   <= '0;
      r_wmPrev      <= 1'b1;
      r_data        <= '0;
      r_nWrite      <= 1'b1;
      r_nShort      <= 1'b1;
      r_nError      <= 1'b1;
      r_packetCount <= '0;
    end else begin
      r_wmPrev <= fx3_th0Watermark;
      r_nWrite <= !w_pop;
      r_nShort <= 1'b1;
      if (w_pop)
        r_data <= fifoData;
      if (fifoFull || w_wmErr)
        r_nError <= 1'b0;
      unique case (1'b1)
        (r_state == ST_IDLE): begin
          if (!fx3_nReady)
            r_state <= ST_ARM;
        end
        (r_state == ST_ARM): begin
          if (fx3_nReady) begin
            r_state <= ST_IDLE;
          end else if (!fx3_th0Ready
                    && fifoLevel >= LVL_START) begin
            r_state     <= ST_BURST;
            r_wordCount <= '0;
          end
        end
        (r_state == ST_BURST): begin
          if (w_pop) begin
            if (w_last) begin
              r_wordCount   <= '0;
              r_packetCount <= r_packetCount + 16'd1;
              r_state       <= ST_ARM;
            end else begin
              r_wordCount <= r_wordCount + 1'b1;
            end
          end else if (fx3_nReady) begin
            r_wordCount <= '0;
            if (r_wordCount != '0) begin
              r_nShort <= 1'b0;
              r_state  <= ST_SHORT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_packetCount <= r_packetCount + 16'd1;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
